rgb_led_sched: RTL and testbench
================================

RGB_LED_SCHED -- requirements
Module: rgb_led_sched

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2000000: number of cycles a granted requester owns the LED (legal range 1 to 2^32-1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 200000: number of LED-off cycles after each ownership period (legal range 1 to 2^32-1).
REQ-003 The block SHALL have input clk, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have input req, 3 bits: per-requester LED ownership request, level-sensitive.
REQ-006 The block SHALL have inputs color0, color1 and color2, 3 bits each: requested colour for requesters 0, 1 and 2, bit order {R,G,B}, 1 = on.
REQ-007 The block SHALL have outputs RGB_R, RGB_G and RGB_B, 1 bit each: LED drive, 1 = on, registered.
REQ-008 The block SHALL have output grant, 3 bits: one-hot current owner, all-zero when no owner, registered.
REQ-009 The block SHALL have output done, 3 bits: 1-cycle pulse on the owner's bit when its hold period completes normally.
REQ-010 The block SHALL have output busy, 1 bit: high in HOLD and GAP states.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-012 In IDLE with req != 0, the arbiter SHALL select one requester by round-robin, starting the search at (last_owner+1) mod 3.
REQ-013 The selection in REQ-012 SHALL occur in the same cycle the request is sampled, with the transition to HOLD on the next edge.
REQ-014 On entering HOLD, grant SHALL go one-hot for the winner and the winner's colour word SHALL be latched into RGB_R/G/B, both effective on the same edge (1-cycle latency from req sampled in IDLE).
REQ-015 The latched colour SHALL remain constant for the whole HOLD; changes on colorN during HOLD SHALL be ignored.
REQ-016 HOLD SHALL last exactly HOLD_CYCLES cycles, with grant high for exactly HOLD_CYCLES cycles, unless aborted per REQ-018.
REQ-017 On the last HOLD cycle with the owner's req still high, done[owner] SHALL pulse for that one cycle and the FSM SHALL move to GAP on the next edge.
REQ-018 If the owner deasserts req during HOLD, the FSM SHALL abort: on the next edge it enters GAP, with no done pulse.
REQ-019 If REQ-017 and REQ-018 coincide (req drops on the final cycle), the cycle SHALL be treated as an abort, with no done pulse.
REQ-020 Requests from non-owners during HOLD or GAP SHALL be ignored (no queuing); they are re-evaluated in IDLE.
REQ-021 In GAP, RGB_R/G/B SHALL be 0, grant SHALL be 0 and busy SHALL be 1 for exactly GAP_CYCLES cycles, after which the FSM returns to IDLE.
REQ-022 last_owner SHALL update on every grant, including aborted ones; a sole persistent requester SHALL be re-granted after each gap.
REQ-023 A colour word of 3'b000 SHALL be legal: the LED stays dark while the grant and timing proceed normally.
REQ-024 The cycle counter SHALL be 32 bits wide, SHALL reset to 0 on every state entry and SHALL never wrap within a state.
REQ-025 In IDLE, the LED SHALL be off, grant 0, done 0 and busy 0.

Reset
REQ-026 Asserting rst_n low SHALL immediately (asynchronously) force: state IDLE, counter 0, RGB_R/G/B 0, grant 0, done 0, busy 0, and last_owner 2, so that requester 0 has first priority.
REQ-027 Reset asserted mid-HOLD or mid-GAP SHALL abandon the period with no done pulse; after deassertion, arbitration restarts from the REQ-026 values.
REQ-028 The first arbitration after rst_n rises SHALL occur on the first rising clock edge at which rst_n is high.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-029 Basic: req=3'b001, color0=3'b110 held -> grant=001 and RGB=110 for exactly 4 cycles starting 1 cycle after the request; done[0] high on the 4th of those cycles; then 2 cycles dark; then re-granted.
REQ-030 Round-robin: req=3'b111 held, colours 100/010/001 -> grant sequence 001,010,100,001; each grant 4 cycles, separated by 2-cycle dark gaps.
REQ-031 Abort: req0 dropped in the 2nd HOLD cycle -> grant=000 and LED dark from the next edge, no done pulse, GAP lasts 2 cycles, then IDLE.
REQ-032 Colour stability: color0 changed from 100 to 011 mid-HOLD -> RGB stays 100 until HOLD ends.
REQ-033 Reset mid-HOLD: rst_n pulsed low while owner=1 -> outputs 0 without waiting for a clock edge; after release with req=3'b011, grant=001 is issued first.
REQ-034 Late requester: req1 asserted during requester 0's GAP -> ignored until IDLE, then granted on the first IDLE cycle (1-cycle latency).

Source files
------------

// File: rtl/rgb_led_sched.sv
// rgb_led_sched
//   Round-robin scheduler that hands an RGB LED to one of three requesters.
//   A granted requester owns the LED for HOLD_CYCLES cycles with its colour
//   latched at grant time. After each ownership period the LED stays dark for
//   GAP_CYCLES cycles. The owner can give up early by dropping its request.
//
// Parameters
//   HOLD_CYCLES : cycles a granted requester owns the LED (>= 1)
//   GAP_CYCLES  : dark cycles after every ownership period (>= 1)
//
// Ports
//   clk                    : clock, rising edge
//   rst_n                  : asynchronous active-low reset
//   req[2:0]               : level-sensitive ownership request per requester
//   color0/1/2[2:0]        : requested colour {R,G,B} per requester, 1 = on
//   RGB_R, RGB_G, RGB_B    : registered LED drive, 1 = on
//   grant[2:0]             : registered one-hot current owner, 0 when none
//   done[2:0]              : one-cycle pulse on the owner's bit when its hold
//                            period completes without an abort
//   busy                   : high while in HOLD or GAP
module rgb_led_sched #(
  parameter logic [31:0] HOLD_CYCLES = 32'd2000000,
  parameter logic [31:0] GAP_CYCLES  = 32'd200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  owner;
  logic [1:0]  last_owner;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [2:0]  win_color;
  logic [1:0]  search_start;
  logic [2:0]  search_sum;
  logic [1:0]  cand;
  logic        hold_last;
  logic        gap_last;

  assign hold_last = (cnt == HOLD_CYCLES - 32'd1);
  assign gap_last  = (cnt == GAP_CYCLES - 32'd1);

  // Round-robin pick: scan the three requesters starting just after the
  // previous owner and take the first one that is requesting.
  always_comb begin
    win_valid    = 1'b0;
    win_idx      = 2'd0;
    search_sum   = 3'd0;
    cand         = 2'd0;
    search_start = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
    for (int i = 0; i < 3; i++) begin
      search_sum = {1'b0, search_start} + 3'(i);
      cand       = (search_sum >= 3'd3) ? 2'(search_sum - 3'd3) : search_sum[1:0];
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_color = color0;
      2'd1:    win_color = color1;
      default: win_color = color2;
    endcase
  end

  // done is only raised when the owner is still requesting on the final hold
  // cycle; a request dropped on that same cycle counts as an abort.
  always_comb begin
    done = 3'b000;
    if (state == HOLD && hold_last && req[owner]) begin
      done = grant;
    end
  end

  // Main FSM. grant and LED drive change together on entry/exit of HOLD so
  // the LED is never lit without a matching owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      grant      <= 3'b000;
      RGB_R      <= 1'b0;
      RGB_G      <= 1'b0;
      RGB_B      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state                 <= HOLD;
            cnt                   <= 32'd0;
            owner                 <= win_idx;
            last_owner            <= win_idx;
            grant                 <= 3'b001 << win_idx;
            {RGB_R, RGB_G, RGB_B} <= win_color;
            busy                  <= 1'b1;
          end
        end
        HOLD: begin
          if (!req[owner] || hold_last) begin
            state                 <= GAP;
            cnt                   <= 32'd0;
            grant                 <= 3'b000;
            {RGB_R, RGB_G, RGB_B} <= 3'b000;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (gap_last) begin
            state <= IDLE;
            cnt   <= 32'd0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state                 <= IDLE;
          cnt                   <= 32'd0;
          grant                 <= 3'b000;
          {RGB_R, RGB_G, RGB_B} <= 3'b000;
          busy                  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched
//   Directed-vector bench for rgb_led_sched with HOLD_CYCLES=4, GAP_CYCLES=2.
//   Inputs change and outputs are sampled just after the falling clock edge.
module tb_rgb_led_sched;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] color0;
  logic [2:0] color1;
  logic [2:0] color2;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic [2:0] grant;
  logic [2:0] done;
  logic       busy;
  logic [2:0] rgb;

  int n_compared;
  int n_mismatched;

  assign rgb = {RGB_R, RGB_G, RGB_B};

  rgb_led_sched #(
    .HOLD_CYCLES(32'd4),
    .GAP_CYCLES (32'd2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .color0(color0),
    .color1(color1),
    .color2(color2),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two cycles and release it on a falling edge with no
  // requests pending.
  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = 3'b000;
    color0 = 3'b000;
    color1 = 3'b000;
    color2 = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_compared++;
    if ({grant, rgb, done, busy} !== 10'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", {grant, rgb, done, busy}, 10'b0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_compared++;
      if ({grant, rgb, done, busy} !== 10'b0) begin
        n_mismatched++;
        $display("[TB] FAIL idle_no_req cycle %0d: got %b expected %b", k, {grant, rgb, done, busy}, 10'b0);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    req    = 3'b001;
    color0 = 3'b110;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= HOLD; k++) begin
        @(negedge clk);
        n_compared++;
        if ({grant, rgb, done, busy} !== {3'b001, 3'b110, (k == HOLD) ? 3'b001 : 3'b000, 1'b1}) begin
          n_mismatched++;
          $display("[TB] FAIL basic_hold rep %0d cycle %0d: got g=%b rgb=%b d=%b b=%b expected g=001 rgb=110 d=%b b=1",
                   rep, k, grant, rgb, done, busy, (k == HOLD) ? 3'b001 : 3'b000);
        end
      end
      for (int k = 1; k <= GAP + 1; k++) begin
        @(negedge clk);
        n_compared++;
        if ({grant, rgb, done, busy} !== {9'b0, (k <= GAP)}) begin
          n_mismatched++;
          $display("[TB] FAIL basic_dark rep %0d cycle %0d: got g=%b rgb=%b d=%b b=%b expected g=000 rgb=000 d=000 b=%b",
                   rep, k, grant, rgb, done, busy, (k <= GAP));
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [2:0] exp_c [4];
    exp_g[0] = 3'b001; exp_c[0] = 3'b100;
    exp_g[1] = 3'b010; exp_c[1] = 3'b010;
    exp_g[2] = 3'b100; exp_c[2] = 3'b001;
    exp_g[3] = 3'b001; exp_c[3] = 3'b100;
    do_reset();
    req    = 3'b111;
    color0 = 3'b100;
    color1 = 3'b010;
    color2 = 3'b001;
    for (int g = 0; g < 4; g++) begin
      for (int k = 1; k <= HOLD; k++) begin
        @(negedge clk);
        n_compared++;
        if ({grant, rgb, done} !== {exp_g[g], exp_c[g], (k == HOLD) ? exp_g[g] : 3'b000}) begin
          n_mismatched++;
          $display("[TB] FAIL rr_hold grant %0d cycle %0d: got g=%b rgb=%b d=%b expected g=%b rgb=%b d=%b",
                   g, k, grant, rgb, done, exp_g[g], exp_c[g], (k == HOLD) ? exp_g[g] : 3'b000);
        end
      end
      if (g < 3) begin
        for (int k = 1; k <= GAP + 1; k++) begin
          @(negedge clk);
          n_compared++;
          if ({grant, rgb, busy} !== {6'b0, (k <= GAP)}) begin
            n_mismatched++;
            $display("[TB] FAIL rr_dark after %0d cycle %0d: got g=%b rgb=%b b=%b expected g=000 rgb=000 b=%b",
                     g, k, grant, rgb, busy, (k <= GAP));
          end
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_abort();
    do_reset();
    req    = 3'b001;
    color0 = 3'b110;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({grant, rgb, done} !== {3'b001, 3'b110, 3'b000}) begin
      n_mismatched++;
      $display("[TB] FAIL abort_pre: got g=%b rgb=%b d=%b expected g=001 rgb=110 d=000", grant, rgb, done);
    end
    req = 3'b000;
    for (int k = 1; k <= GAP + 2; k++) begin
      @(negedge clk);
      n_compared++;
      if ({grant, rgb, done, busy} !== {9'b0, (k <= GAP)}) begin
        n_mismatched++;
        $display("[TB] FAIL abort_after cycle %0d: got g=%b rgb=%b d=%b b=%b expected g=000 rgb=000 d=000 b=%b",
                 k, grant, rgb, done, busy, (k <= GAP));
      end
    end
  endtask

  task automatic test_abort_last_cycle();
    do_reset();
    req    = 3'b001;
    color0 = 3'b001;
    for (int k = 1; k <= HOLD; k++) @(negedge clk);
    n_compared++;
    if (done !== 3'b001) begin
      n_mismatched++;
      $display("[TB] FAIL last_cycle_done_with_req: got %b expected 001", done);
    end
    req = 3'b000;
    #1;
    n_compared++;
    if (done !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL last_cycle_done_after_drop: got %b expected 000", done);
    end
    @(negedge clk);
    n_compared++;
    if ({grant, rgb, done, busy} !== 10'b0000000001) begin
      n_mismatched++;
      $display("[TB] FAIL last_cycle_gap: got %b expected %b", {grant, rgb, done, busy}, 10'b0000000001);
    end
  endtask

  task automatic test_color_stable();
    do_reset();
    req    = 3'b001;
    color0 = 3'b100;
    @(negedge clk);
    color0 = 3'b011;
    for (int k = 2; k <= HOLD; k++) begin
      @(negedge clk);
      n_compared++;
      if (rgb !== 3'b100) begin
        n_mismatched++;
        $display("[TB] FAIL color_stable cycle %0d: got %b expected 100", k, rgb);
      end
    end
    @(negedge clk);
    n_compared++;
    if (rgb !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL color_gap_dark: got %b expected 000", rgb);
    end
    req = 3'b000;
  endtask

  task automatic test_dark_colour();
    do_reset();
    req    = 3'b100;
    color2 = 3'b000;
    color0 = 3'b111;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      n_compared++;
      if ({grant, rgb, done} !== {3'b100, 3'b000, (k == HOLD) ? 3'b100 : 3'b000}) begin
        n_mismatched++;
        $display("[TB] FAIL dark_colour cycle %0d: got g=%b rgb=%b d=%b expected g=100 rgb=000 d=%b",
                 k, grant, rgb, done, (k == HOLD) ? 3'b100 : 3'b000);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req    = 3'b010;
    color0 = 3'b101;
    color1 = 3'b011;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({grant, rgb} !== {3'b010, 3'b011}) begin
      n_mismatched++;
      $display("[TB] FAIL mid_hold_pre: got g=%b rgb=%b expected g=010 rgb=011", grant, rgb);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({grant, rgb, done, busy} !== 10'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got %b expected %b", {grant, rgb, done, busy}, 10'b0);
    end
    req = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({grant, rgb} !== {3'b001, 3'b101}) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_first: got g=%b rgb=%b expected g=001 rgb=101", grant, rgb);
    end
    for (int k = 1; k < HOLD + GAP + 2; k++) @(negedge clk);
    n_compared++;
    if ({grant, rgb} !== {3'b010, 3'b011}) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_second: got g=%b rgb=%b expected g=010 rgb=011", grant, rgb);
    end
    req = 3'b000;
  endtask

  task automatic test_late_requester();
    do_reset();
    req    = 3'b001;
    color1 = 3'b010;
    for (int k = 1; k <= HOLD + 1; k++) @(negedge clk);
    n_compared++;
    if ({grant, busy} !== 4'b0001) begin
      n_mismatched++;
      $display("[TB] FAIL late_gap_entry: got g=%b b=%b expected g=000 b=1", grant, busy);
    end
    req = 3'b010;
    @(negedge clk);
    n_compared++;
    if ({grant, busy} !== 4'b0001) begin
      n_mismatched++;
      $display("[TB] FAIL late_ignored_in_gap: got g=%b b=%b expected g=000 b=1", grant, busy);
    end
    @(negedge clk);
    n_compared++;
    if ({grant, busy} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL late_idle: got g=%b b=%b expected g=000 b=0", grant, busy);
    end
    @(negedge clk);
    n_compared++;
    if ({grant, rgb, busy} !== {3'b010, 3'b010, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL late_granted: got g=%b rgb=%b b=%b expected g=010 rgb=010 b=1", grant, rgb, busy);
    end
    req = 3'b000;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    req          = 3'b000;
    color0       = 3'b000;
    color1       = 3'b000;
    color2       = 3'b000;
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_abort_last_cycle();
    test_color_stable();
    test_dark_colour();
    test_reset_mid_hold();
    test_late_requester();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
